// File: rtl/instr_sequencer.sv
// Program sequencer: replays a stored 9-bit program to the processor over Din/run.
// Latency: start to first run is 2 cycles; each instruction takes LOAD + ISSUE + execute cycles.
// Backpressure: holds in WAIT until Done and errors after TIMEOUT idle cycles; writes/start ignored while busy.
module instr_sequencer #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [8:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          Done,
    output logic [8:0]    Din,
    output logic          run,
    output logic          busy,
    output logic          finished,
    output logic          error,
    output logic [AW:0]   pc
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t        state;
    logic [AW:0]   len;
    logic [CW-1:0] cnt;
    logic [8:0]    mem [DEPTH];

    logic [AW:0]   pc_inc1;
    logic [AW:0]   pc_step;
    logic [8:0]    word_cur;
    logic [8:0]    word_nxt;
    logic          is_mvi;
    logic          is_halt;

    assign pc_inc1  = pc + (AW + 1)'(1);
    assign word_cur = (pc < DEPTH_W) ? mem[pc[AW-1:0]] : 9'd0;
    assign word_nxt = (pc_inc1 < DEPTH_W) ? mem[pc_inc1[AW-1:0]] : 9'd0;
    assign is_mvi   = (word_cur[8:6] == 3'b001);
    assign is_halt  = word_cur[8];
    assign pc_step  = is_mvi ? pc + (AW + 1)'(2) : pc_inc1;

    assign run  = (state == S_ISSUE);
    assign busy = (state == S_LOAD) || (state == S_ISSUE) || (state == S_WAIT);

    // During the WAIT of an mvi the immediate is presented so it is valid when Done fires.
    always_comb begin
        Din = 9'd0;
        case (state)
            S_LOAD, S_ISSUE: Din = word_cur;
            S_WAIT:          Din = is_mvi ? word_nxt : word_cur;
            default:         Din = 9'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (prog_we && !busy && ({1'b0, prog_addr} < DEPTH_W)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            pc       <= '0;
            len      <= '0;
            cnt      <= '0;
            finished <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FINISH, S_ERROR: begin
                    if (start) begin
                        len      <= prog_len;
                        pc       <= '0;
                        cnt      <= '0;
                        error    <= 1'b0;
                        if (prog_len == '0) begin
                            state    <= S_FINISH;
                            finished <= 1'b1;
                        end else begin
                            state    <= S_LOAD;
                            finished <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (is_halt) begin
                        state    <= S_FINISH;
                        finished <= 1'b1;
                    end else if (is_mvi && (pc_inc1 >= len)) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (Done) begin
                        pc <= pc_step;
                        if (pc_step >= len) begin
                            state    <= S_FINISH;
                            finished <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // TIMEOUT WAIT cycles have elapsed with no Done.
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: processor stand-in answers run/Done, trace model predicts run timing and results.
module tb_instr_sequencer;
    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 15;
    localparam int NCYC    = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn    = 1'b0;
    logic          prog_we   = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [8:0]    prog_data = '0;
    logic [AW:0]   prog_len  = '0;
    logic          start     = 1'b0;
    logic          Done      = 1'b0;
    logic [8:0]    Din;
    logic          run, busy, finished, error;
    logic [AW:0]   pc;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .Done(Done),
        .Din(Din), .run(run), .busy(busy), .finished(finished), .error(error), .pc(pc)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] shadow [DEPTH];
    bit         exp_run [NCYC];
    logic [8:0] exp_word [NCYC];
    logic [8:0] exp_reg [8];
    logic [8:0] breg [8];
    logic [8:0] obs_din [NCYC];
    logic       obs_run [NCYC];
    logic       obs_fin [NCYC];
    logic       obs_err [NCYC];
    int         end_cyc, end_pc;
    bit         end_fin, end_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [8:0] d);
        prog_we   = 1'b1;
        prog_addr = a[AW-1:0];
        prog_data = d;
        shadow[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Trace model: cycle 0 is the start cycle, LOAD of the first word is cycle 1.
    task automatic ref_run(input int len, input bit nodone);
        int t, p, ex, x, y;
        logic [8:0] w;
        for (int k = 0; k < NCYC; k++) begin
            exp_run[k]  = 1'b0;
            exp_word[k] = 9'd0;
        end
        for (int r = 0; r < 8; r++) exp_reg[r] = 9'd0;
        end_fin = 1'b0;
        end_err = 1'b0;
        p = 0;
        t = 1;
        if (len == 0) begin
            end_cyc = 1; end_fin = 1'b1; end_pc = 0;
            return;
        end
        forever begin
            w = shadow[p];
            if (w[8]) begin
                end_cyc = t + 1; end_fin = 1'b1; end_pc = p;
                return;
            end
            if (w[8:6] == 3'b001 && p + 1 >= len) begin
                end_cyc = t + 1; end_err = 1'b1; end_pc = p;
                return;
            end
            exp_run[t + 1]  = 1'b1;
            exp_word[t + 1] = w;
            ex = w[7] ? 3 : 1;
            if (nodone) begin
                end_cyc = t + 2 + TIMEOUT; end_err = 1'b1; end_pc = p;
                return;
            end
            x = int'(w[5:3]);
            y = int'(w[2:0]);
            case (w[7:6])
                2'd0: exp_reg[x] = exp_reg[y];
                2'd1: exp_reg[x] = shadow[p + 1];
                2'd2: exp_reg[x] = exp_reg[x] + exp_reg[y];
                default: exp_reg[x] = exp_reg[x] - exp_reg[y];
            endcase
            p = p + ((w[7:6] == 2'd1) ? 2 : 1);
            t = t + 2 + ex;
            if (p >= len) begin
                end_cyc = t; end_fin = 1'b1; end_pc = p;
                return;
            end
        end
    endtask

    task automatic bfm_exec(input logic [8:0] ir, input logic [8:0] d);
        int x, y;
        x = int'(ir[5:3]);
        y = int'(ir[2:0]);
        case (ir[7:6])
            2'd0: breg[x] = breg[y];
            2'd1: breg[x] = d;
            2'd2: breg[x] = breg[x] + breg[y];
            default: breg[x] = breg[x] - breg[y];
        endcase
    endtask

    // inj: 1 = write+start while busy at cycle 3, 2 = Done pulse during the first LOAD.
    // abort_cyc: nonzero drops resetn at that cycle and checks the aborted state next cycle.
    task automatic run_prog(input string tag, input int len, input bit nodone,
                            input int inj, input int abort_cyc);
        int cnt;
        bit pending;
        logic [8:0] ir;
        ref_run(len, nodone);
        for (int r = 0; r < 8; r++) breg[r] = 9'd0;
        pending = 1'b0;
        cnt = 0;
        ir = 9'd0;
        start = 1'b1;
        prog_len = len[AW:0];
        for (int k = 1; k <= end_cyc + 1; k++) begin
            @(negedge clk);
            start   = 1'b0;
            prog_we = 1'b0;
            Done    = 1'b0;
            obs_din[k] = Din;
            obs_run[k] = run;
            obs_fin[k] = finished;
            obs_err[k] = error;
            if (abort_cyc != 0 && k == abort_cyc + 1) begin
                chk($sformatf("%s abort run", tag), run, 0);
                chk($sformatf("%s abort Din", tag), Din, 0);
                chk($sformatf("%s abort pc", tag), pc, 0);
                chk($sformatf("%s abort busy", tag), busy, 0);
                chk($sformatf("%s abort finished", tag), finished, 0);
                chk($sformatf("%s abort error", tag), error, 0);
                resetn = 1'b1;
                return;
            end
            chk($sformatf("%s c%0d run", tag, k), run, exp_run[k]);
            chk($sformatf("%s c%0d busy", tag, k), busy, (k < end_cyc) ? 1 : 0);
            chk($sformatf("%s c%0d finished", tag, k), finished, (k >= end_cyc) ? end_fin : 0);
            chk($sformatf("%s c%0d error", tag, k), error, (k >= end_cyc) ? end_err : 0);
            if (exp_run[k]) chk($sformatf("%s c%0d Din", tag, k), Din, exp_word[k]);
            if (k == 1) chk($sformatf("%s c1 pc", tag), pc, 0);
            if (k == end_cyc) chk($sformatf("%s end pc", tag), pc, end_pc);
            if (run) begin
                ir = Din;
                cnt = Din[7] ? 3 : 1;
                pending = 1'b1;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending = 1'b0;
                    if (!nodone) begin
                        Done = 1'b1;
                        bfm_exec(ir, Din);
                    end
                end
            end
            if (inj == 1 && k == 3) begin
                prog_we   = 1'b1;
                prog_addr = '0;
                prog_data = ~shadow[0];
                start     = 1'b1;
                prog_len  = 1;
            end
            if (inj == 2 && k == 1) Done = 1'b1;
            if (inj == 2 && k == 2) chk($sformatf("%s pc after LOAD Done", tag), pc, 0);
            if (abort_cyc != 0 && k == abort_cyc) resetn = 1'b0;
        end
        for (int r = 0; r < 8; r++)
            chk($sformatf("%s R%0d", tag, r), breg[r], exp_reg[r]);
    endtask

    task automatic load_p1();
        wr(0, 9'h040); wr(1, 9'h005); wr(2, 9'h008); wr(3, 9'h100);
    endtask

    task automatic load_p2();
        wr(0, 9'h040); wr(1, 9'h003); wr(2, 9'h048); wr(3, 9'h002); wr(4, 9'h081);
    endtask

    initial begin
        logic [8:0] w;
        int len;
        repeat (3) @(negedge clk);
        chk("reset run", run, 0);
        chk("reset Din", Din, 0);
        chk("reset busy", busy, 0);
        chk("reset finished", finished, 0);
        chk("reset error", error, 0);
        chk("reset pc", pc, 0);
        resetn = 1'b1;
        @(negedge clk);
        for (int a = 0; a < DEPTH; a++) wr(a, 9'd0);

        load_p1();
        run_prog("p1", 4, 1'b0, 0, 0);
        chk("p1 run@2", obs_run[2], 1);
        chk("p1 run@5", obs_run[5], 1);
        chk("p1 imm@3", obs_din[3], 9'h005);
        chk("p1 R0", breg[0], 5);
        chk("p1 R1", breg[1], 5);
        chk("p1 pc", pc, 3);

        load_p2();
        run_prog("p2", 5, 1'b0, 0, 0);
        chk("p2 R0", breg[0], 5);
        chk("p2 add run@8", obs_run[8], 1);
        chk("p2 fin@11", obs_fin[11], 0);
        chk("p2 fin@12", obs_fin[12], 1);
        chk("p2 pc", pc, 5);

        wr(0, 9'h040);
        run_prog("trunc", 1, 1'b0, 0, 0);
        chk("trunc no run", obs_run[2], 0);
        chk("trunc error", error, 1);
        chk("trunc busy", busy, 0);

        wr(0, 9'h081);
        run_prog("tmo", 1, 1'b1, 0, 0);
        chk("tmo issue", obs_run[2], 1);
        chk("tmo err early", obs_err[2 + TIMEOUT], 0);
        chk("tmo err rise", obs_err[3 + TIMEOUT], 1);
        run_prog("tmo restart", 1, 1'b0, 0, 0);
        chk("tmo restart pc", pc, 1);

        load_p1();
        run_prog("busy inj", 4, 1'b0, 1, 0);
        run_prog("busy recheck", 4, 1'b0, 0, 0);
        chk("busy store word0", obs_din[2], 9'h040);
        run_prog("done in load", 4, 1'b0, 2, 0);

        load_p2();
        run_prog("abort", 5, 1'b0, 0, 9);
        run_prog("rerun", 5, 1'b0, 0, 0);
        chk("rerun R0", breg[0], 5);

        for (int it = 0; it < 30; it++) begin
            for (int a = 1; a < DEPTH; a++) begin
                w = 9'($urandom);
                if ($urandom_range(0, 15) == 0) w[8] = 1'b1;
                else w[8] = 1'b0;
                wr(a, w);
            end
            w = 9'($urandom);
            w[8] = 1'b0;
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = w;
            shadow[0] = w;
            len = $urandom_range(0, DEPTH);
            run_prog($sformatf("rnd%0d", it), len, 1'b0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
